// File: rtl/cp0_nested_irq_if.sv
// Signal bundle between the CPU pipeline and the nested CP0 interrupt block.
// The master side drives requests and pipeline context; the slave side is the interrupt block.
interface cp0_nested_irq_if #(
    parameter int N_IRQ = 8,
    parameter int PC_W  = 32
);
    logic [N_IRQ-1:0] hardware_interrupt;
    logic [PC_W-1:0]  current_pc;
    logic             eret;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic             pc_jump;
    logic [PC_W-1:0]  pc_addr;
    logic             writeback_mask;
    logic             interrupt;
    logic [PC_W-1:0]  epc;
    logic [31:0]      status;
    logic [N_IRQ-1:0] pending;

    modport master (
        output hardware_interrupt, current_pc, eret, mask_we, mask_wdata,
        input  pc_jump, pc_addr, writeback_mask, interrupt, epc, status, pending
    );

    modport slave (
        input  hardware_interrupt, current_pc, eret, mask_we, mask_wdata,
        output pc_jump, pc_addr, writeback_mask, interrupt, epc, status, pending
    );
endinterface

// File: rtl/cp0_nested_irq.sv
// Edge-latched, fixed-priority, maskable interrupt controller with preemptive nesting via an EPC/level stack.
// Redirect outputs are combinational from state and this cycle's inputs; a request edge can redirect the next cycle.
module cp0_nested_irq #(
    parameter int              N_IRQ      = 8,
    parameter int              DEPTH      = 4,
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(32'h100),
    parameter logic [PC_W-1:0] VEC_STRIDE = PC_W'(32'h10)
) (
    input  logic              clk,
    input  logic              clr_n,
    cp0_nested_irq_if.slave   bus
);
    localparam int DW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {ACT_RUN, ACT_TAKE, ACT_ERET} act_t;

    logic [N_IRQ-1:0] pending, prev, mask;
    logic [DW-1:0]    depth;
    logic [4:0]       level;
    logic             err;
    logic [PC_W-1:0]  stk_epc [DEPTH];
    logic [4:0]       stk_lvl [DEPTH];

    act_t             act;
    logic [N_IRQ-1:0] rise, pending_nxt;
    logic [DW-1:0]    depth_nxt;
    logic [4:0]       level_nxt;
    logic             err_nxt;
    logic             cand_vld, eligible;
    logic [3:0]       cand_idx;
    logic [PC_W-1:0]  top_epc;
    logic [4:0]       top_lvl;

    assign rise = bus.hardware_interrupt & ~prev;

    always_comb begin
        top_epc = '0;
        top_lvl = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (DW'(k) == depth - DW'(1)) begin
                top_epc = stk_epc[k];
                top_lvl = stk_lvl[k];
            end
        end
    end

    // Scan from the lowest priority up so the lowest index wins.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pending[i] && mask[i]) begin
                cand_vld = 1'b1;
                cand_idx = 4'(i);
            end
        end
    end

    assign eligible = cand_vld && (depth < DW'(DEPTH)) &&
                      ((level == 5'd0) || ((5'(cand_idx) + 5'd1) < level));

    always_comb begin
        act                = ACT_RUN;
        bus.pc_jump        = 1'b0;
        bus.pc_addr        = '0;
        bus.writeback_mask = 1'b1;
        depth_nxt          = depth;
        level_nxt          = level;
        err_nxt            = err;
        pending_nxt        = pending | rise;
        if (bus.eret) begin
            if (depth != '0) begin
                act         = ACT_ERET;
                bus.pc_jump = 1'b1;
                bus.pc_addr = top_epc;
                depth_nxt   = depth - DW'(1);
                level_nxt   = top_lvl;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (eligible) begin
            act                = ACT_TAKE;
            bus.pc_jump        = 1'b1;
            bus.pc_addr        = VEC_BASE + VEC_STRIDE * PC_W'(cand_idx);
            bus.writeback_mask = 1'b0;
            depth_nxt          = depth + DW'(1);
            level_nxt          = 5'(cand_idx) + 5'd1;
            // A fresh edge on the channel being taken must survive the clear.
            pending_nxt        = (pending & ~(N_IRQ'(1) << cand_idx)) | rise;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pending <= '0;
            prev    <= '0;
            mask    <= '1;
            depth   <= '0;
            level   <= '0;
            err     <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                stk_epc[k] <= '0;
                stk_lvl[k] <= '0;
            end
        end else begin
            prev    <= bus.hardware_interrupt;
            pending <= pending_nxt;
            depth   <= depth_nxt;
            level   <= level_nxt;
            err     <= err_nxt;
            if (bus.mask_we) mask <= bus.mask_wdata;
            for (int k = 0; k < DEPTH; k++) begin
                if (act == ACT_TAKE && DW'(k) == depth) begin
                    stk_epc[k] <= bus.current_pc;
                    stk_lvl[k] <= level;
                end
            end
        end
    end

    assign bus.interrupt = (depth != '0);
    assign bus.epc       = (depth != '0) ? top_epc : '0;
    assign bus.pending   = pending;
    assign bus.status    = {err, 3'(depth), 7'd0, level, 16'(mask)};

endmodule

// File: tb/tb_cp0_nested_irq.sv
// Directed table of per-cycle vectors plus hand-written reset sequences for cp0_nested_irq (DEPTH=2).
module tb_cp0_nested_irq;
    logic clk = 1'b0;
    logic clr_n;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    cp0_nested_irq_if #(.N_IRQ(8), .PC_W(32)) bus ();

    cp0_nested_irq #(.N_IRQ(8), .DEPTH(2), .PC_W(32)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0]  irq;
        logic [31:0] pc;
        logic        eret;
        logic        mwe;
        logic [7:0]  mwd;
        logic        jump;
        logic [31:0] addr;
        logic        wbm;
        logic [1:0]  dep;
        logic [4:0]  lvl;
        logic [7:0]  pend;
        logic [31:0] epc;
        logic [7:0]  msk;
        logic        err;
    } vec_t;

    vec_t tbl [34];

    function automatic vec_t mk(logic [7:0] irq, logic [31:0] pc, logic er, logic mwe,
                                logic [7:0] mwd, logic jump, logic [31:0] addr, logic wbm,
                                logic [1:0] dep, logic [4:0] lvl, logic [7:0] pend,
                                logic [31:0] epc, logic [7:0] msk, logic err);
        vec_t v;
        v.irq = irq; v.pc = pc; v.eret = er; v.mwe = mwe; v.mwd = mwd;
        v.jump = jump; v.addr = addr; v.wbm = wbm; v.dep = dep; v.lvl = lvl;
        v.pend = pend; v.epc = epc; v.msk = msk; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input logic [7:0] irq, input logic [31:0] pc, input logic er,
                         input logic mwe, input logic [7:0] mwd);
        bus.hardware_interrupt = irq;
        bus.current_pc         = pc;
        bus.eret               = er;
        bus.mask_we            = mwe;
        bus.mask_wdata         = mwd;
    endtask

    task automatic chk_reset(input int tag);
        chk("rst_pending", tag, 32'(bus.pending), 32'h0);
        chk("rst_status", tag, bus.status, 32'h0000_00FF);
        chk("rst_pc_jump", tag, 32'(bus.pc_jump), 32'h0);
        chk("rst_wb_mask", tag, 32'(bus.writeback_mask), 32'h1);
        chk("rst_interrupt", tag, 32'(bus.interrupt), 32'h0);
        chk("rst_epc", tag, bus.epc, 32'h0);
    endtask

    initial begin
        //           irq    pc      er mwe mwd   jmp addr    wbm dep lvl pend   epc     msk    err
        tbl[0]  = mk(8'h00, 32'h1F, 0, 0, 8'h00, 0, 32'h0,   1, 0, 0, 8'h00, 32'h0,   8'hFF, 0);
        tbl[1]  = mk(8'h08, 32'h20, 0, 0, 8'h00, 0, 32'h0,   1, 0, 0, 8'h00, 32'h0,   8'hFF, 0);
        tbl[2]  = mk(8'h00, 32'h20, 0, 0, 8'h00, 1, 32'h130, 0, 0, 0, 8'h08, 32'h0,   8'hFF, 0);
        tbl[3]  = mk(8'h00, 32'h130,0, 0, 8'h00, 0, 32'h0,   1, 1, 4, 8'h00, 32'h20,  8'hFF, 0);
        tbl[4]  = mk(8'h02, 32'h134,0, 0, 8'h00, 0, 32'h0,   1, 1, 4, 8'h00, 32'h20,  8'hFF, 0);
        tbl[5]  = mk(8'h00, 32'h135,0, 0, 8'h00, 1, 32'h110, 0, 1, 4, 8'h02, 32'h20,  8'hFF, 0);
        tbl[6]  = mk(8'h20, 32'h110,0, 0, 8'h00, 0, 32'h0,   1, 2, 2, 8'h00, 32'h135, 8'hFF, 0);
        tbl[7]  = mk(8'h00, 32'h111,0, 0, 8'h00, 0, 32'h0,   1, 2, 2, 8'h20, 32'h135, 8'hFF, 0);
        tbl[8]  = mk(8'h01, 32'h112,0, 0, 8'h00, 0, 32'h0,   1, 2, 2, 8'h20, 32'h135, 8'hFF, 0);
        tbl[9]  = mk(8'h00, 32'h113,0, 0, 8'h00, 0, 32'h0,   1, 2, 2, 8'h21, 32'h135, 8'hFF, 0);
        tbl[10] = mk(8'h00, 32'h114,1, 0, 8'h00, 1, 32'h135, 1, 2, 2, 8'h21, 32'h135, 8'hFF, 0);
        tbl[11] = mk(8'h00, 32'h135,0, 0, 8'h00, 1, 32'h100, 0, 1, 4, 8'h21, 32'h20,  8'hFF, 0);
        tbl[12] = mk(8'h00, 32'h100,0, 0, 8'h00, 0, 32'h0,   1, 2, 1, 8'h20, 32'h135, 8'hFF, 0);
        tbl[13] = mk(8'h00, 32'h101,1, 0, 8'h00, 1, 32'h135, 1, 2, 1, 8'h20, 32'h135, 8'hFF, 0);
        tbl[14] = mk(8'h01, 32'h135,0, 0, 8'h00, 0, 32'h0,   1, 1, 4, 8'h20, 32'h20,  8'hFF, 0);
        tbl[15] = mk(8'h00, 32'h136,1, 0, 8'h00, 1, 32'h20,  1, 1, 4, 8'h21, 32'h20,  8'hFF, 0);
        tbl[16] = mk(8'h00, 32'h20, 0, 0, 8'h00, 1, 32'h100, 0, 0, 0, 8'h21, 32'h0,   8'hFF, 0);
        tbl[17] = mk(8'h00, 32'h100,1, 0, 8'h00, 1, 32'h20,  1, 1, 1, 8'h20, 32'h20,  8'hFF, 0);
        tbl[18] = mk(8'h00, 32'h20, 0, 0, 8'h00, 1, 32'h150, 0, 0, 0, 8'h20, 32'h0,   8'hFF, 0);
        tbl[19] = mk(8'h00, 32'h150,1, 0, 8'h00, 1, 32'h20,  1, 1, 6, 8'h00, 32'h20,  8'hFF, 0);
        tbl[20] = mk(8'h00, 32'h20, 1, 0, 8'h00, 0, 32'h0,   1, 0, 0, 8'h00, 32'h0,   8'hFF, 0);
        tbl[21] = mk(8'h00, 32'h21, 0, 1, 8'h00, 0, 32'h0,   1, 0, 0, 8'h00, 32'h0,   8'hFF, 1);
        tbl[22] = mk(8'h04, 32'h22, 0, 0, 8'h00, 0, 32'h0,   1, 0, 0, 8'h00, 32'h0,   8'h00, 1);
        tbl[23] = mk(8'h00, 32'h23, 0, 0, 8'h00, 0, 32'h0,   1, 0, 0, 8'h04, 32'h0,   8'h00, 1);
        tbl[24] = mk(8'h00, 32'h24, 0, 1, 8'h04, 0, 32'h0,   1, 0, 0, 8'h04, 32'h0,   8'h00, 1);
        tbl[25] = mk(8'h00, 32'h25, 0, 1, 8'h00, 1, 32'h120, 0, 0, 0, 8'h04, 32'h0,   8'h04, 1);
        tbl[26] = mk(8'h04, 32'h120,0, 0, 8'h00, 0, 32'h0,   1, 1, 3, 8'h00, 32'h25,  8'h00, 1);
        tbl[27] = mk(8'h04, 32'h121,1, 0, 8'h00, 1, 32'h25,  1, 1, 3, 8'h04, 32'h25,  8'h00, 1);
        tbl[28] = mk(8'h00, 32'h25, 0, 1, 8'hFF, 0, 32'h0,   1, 0, 0, 8'h04, 32'h0,   8'h00, 1);
        tbl[29] = mk(8'h04, 32'h26, 0, 0, 8'h00, 1, 32'h120, 0, 0, 0, 8'h04, 32'h0,   8'hFF, 1);
        tbl[30] = mk(8'h00, 32'h120,0, 0, 8'h00, 0, 32'h0,   1, 1, 3, 8'h04, 32'h26,  8'hFF, 1);
        tbl[31] = mk(8'h00, 32'h121,1, 0, 8'h00, 1, 32'h26,  1, 1, 3, 8'h04, 32'h26,  8'hFF, 1);
        tbl[32] = mk(8'h00, 32'h26, 0, 0, 8'h00, 1, 32'h120, 0, 0, 0, 8'h04, 32'h0,   8'hFF, 1);
        tbl[33] = mk(8'h00, 32'h120,0, 0, 8'h00, 0, 32'h0,   1, 1, 3, 8'h00, 32'h26,  8'hFF, 1);

        // Power-on reset with every request line held high.
        clr_n = 1'b0;
        drive(8'hFF, 32'h0, 1'b0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset(-1);
        @(posedge clk);
        #1;
        drive(8'h00, 32'h0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        clr_n = 1'b1;

        for (int r = 0; r < 34; r++) begin
            logic [31:0] exp_status;
            drive(tbl[r].irq, tbl[r].pc, tbl[r].eret, tbl[r].mwe, tbl[r].mwd);
            @(negedge clk);
            exp_status = {tbl[r].err, 1'b0, tbl[r].dep, 7'd0, tbl[r].lvl, 8'h00, tbl[r].msk};
            chk("pc_jump", r, 32'(bus.pc_jump), 32'(tbl[r].jump));
            chk("pc_addr", r, bus.pc_addr, tbl[r].addr);
            chk("writeback_mask", r, 32'(bus.writeback_mask), 32'(tbl[r].wbm));
            chk("status", r, bus.status, exp_status);
            chk("pending", r, 32'(bus.pending), 32'(tbl[r].pend));
            chk("epc", r, bus.epc, tbl[r].epc);
            chk("interrupt", r, 32'(bus.interrupt), 32'(tbl[r].dep != 2'd0));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a handler: state clears without a clock edge.
        drive(8'h00, 32'h121, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("pre_rst_interrupt", 100, 32'(bus.interrupt), 32'h1);
        #2;
        clr_n = 1'b0;
        drive(8'hFF, 32'h121, 1'b0, 1'b0, 8'h00);
        #1;
        chk_reset(101);
        @(posedge clk);
        #1;
        chk_reset(102);
        drive(8'h00, 32'h0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        @(negedge clk);
        chk_reset(103);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
